miriscv_mdu_iter: RTL and testbench

- Parametrised iterative multiply/divide unit for the miriscv execute stage. Implements all eight RV M-extension ops encoded by the miriscv_mdu_pkg op codes.
- Generalises the fixed 32-bit MDU to XLEN and to a configurable multiplier radix. Adds a request/valid handshake, a kill input and single-cycle fast paths for divide special cases.

---
 rtl/miriscv_mdu_pkg.sv | 38 +++
 rtl/miriscv_div_radix2.sv | 67 ++++++
 rtl/miriscv_mdu_iter.sv | 157 +++++++++++++++
 tb/tb_miriscv_mdu_iter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/miriscv_mdu_pkg.sv
// Shared definitions for the miriscv multiply/divide unit: RV M op codes,
// FSM state encoding and op-classification helpers.
package miriscv_mdu_pkg;

  localparam int MDU_OP_WIDTH = 3;

  localparam logic [MDU_OP_WIDTH-1:0] MDU_MUL    = 3'b000;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_MULH   = 3'b001;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_MULHSU = 3'b010;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_MULHU  = 3'b011;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_DIV    = 3'b100;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_DIVU   = 3'b101;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_REM    = 3'b110;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} mdu_state_t;

  function automatic logic is_mul_op(input logic [MDU_OP_WIDTH-1:0] op);
    return op inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_MULHU};
  endfunction

  function automatic logic is_signed_a(input logic [MDU_OP_WIDTH-1:0] op);
    return op inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
  endfunction

  function automatic logic is_signed_b(input logic [MDU_OP_WIDTH-1:0] op);
    return op inside {MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM};
  endfunction

  function automatic logic is_high_op(input logic [MDU_OP_WIDTH-1:0] op);
    return op inside {MDU_MULH, MDU_MULHSU, MDU_MULHU};
  endfunction

  function automatic logic is_rem_op(input logic [MDU_OP_WIDTH-1:0] op);
    return op inside {MDU_REM, MDU_REMU};
  endfunction

endpackage

// File: rtl/miriscv_div_radix2.sv
// Iterative restoring radix-2 divider on unsigned magnitudes; one quotient bit
// per cycle, XLEN cycles. quotient_o/remainder_o carry the current step result.
module miriscv_div_radix2 #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            arstn_i,
  input  logic            start_i,
  input  logic            kill_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            done_o,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);

  localparam int CNT_W = $clog2(XLEN);

  logic             running;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  quo;
  logic [XLEN-1:0]  rem;
  logic [XLEN-1:0]  dvs;
  logic [XLEN:0]    rem_sh;
  logic [XLEN:0]    diff;

  // quo doubles as the dividend shift register: its MSB feeds the partial remainder
  always_comb begin
    rem_sh = {rem, quo[XLEN-1]};
    diff   = rem_sh - {1'b0, dvs};
    if (!diff[XLEN]) begin
      remainder_o = diff[XLEN-1:0];
      quotient_o  = {quo[XLEN-2:0], 1'b1};
    end else begin
      remainder_o = rem_sh[XLEN-1:0];
      quotient_o  = {quo[XLEN-2:0], 1'b0};
    end
    done_o = running && (cnt == CNT_W'(XLEN-1));
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      running <= 1'b0;
      cnt     <= '0;
    end else if (kill_i) begin
      running <= 1'b0;
    end else if (start_i) begin
      running <= 1'b1;
      cnt     <= '0;
    end else if (running) begin
      cnt <= cnt + 1'b1;
      if (done_o) running <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (start_i) begin
      quo <= dividend_i;
      rem <= '0;
      dvs <= divisor_i;
    end else if (running) begin
      quo <= quotient_o;
      rem <= remainder_o;
    end
  end

endmodule

// File: rtl/miriscv_mdu_iter.sv
// Iterative RV M-extension multiply/divide unit with request/valid handshake,
// kill, and single-cycle results for divide-by-zero and signed overflow.
module miriscv_mdu_iter
  import miriscv_mdu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 32
) (
  input  logic                    clk_i,
  input  logic                    arstn_i,
  input  logic                    mdu_req_i,
  input  logic [MDU_OP_WIDTH-1:0] mdu_op_i,
  input  logic [XLEN-1:0]         mdu_port_a_i,
  input  logic [XLEN-1:0]         mdu_port_b_i,
  input  logic                    mdu_kill_i,
  output logic                    mdu_ready_o,
  output logic                    mdu_valid_o,
  output logic [XLEN-1:0]         mdu_result_o,
  output logic                    mdu_busy_o
);

  localparam int MUL_ITERS = XLEN / MUL_BITS;
  localparam int CNT_W     = (MUL_ITERS > 1) ? $clog2(MUL_ITERS) : 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  generate
    if (XLEN < 8 || (XLEN % 2) != 0) begin : g_bad_xlen
      $error("miriscv_mdu_iter: XLEN must be even and at least 8");
    end
    if (MUL_BITS < 1 || (XLEN % MUL_BITS) != 0) begin : g_bad_mul_bits
      $error("miriscv_mdu_iter: MUL_BITS must divide XLEN");
    end
  endgenerate

  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
    return '0 - v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v);
    return '0 - v;
  endfunction

  mdu_state_t              state;
  logic [CNT_W-1:0]        mul_cnt;
  logic [MDU_OP_WIDTH-1:0] op_q;
  logic                    sign_a_q, sign_b_q;
  logic [XLEN-1:0]         res_pend, res_hold;
  logic [2*XLEN-1:0]       acc, mcand_sh, mul_digit, acc_next, prod;
  logic [XLEN-1:0]         mplier, mul_res, div_res;

  logic                    accept, sign_a_in, sign_b_in, div_special, div_start, mul_last;
  logic [XLEN-1:0]         abs_a_in, abs_b_in, special_res;
  logic                    div_done;
  logic [XLEN-1:0]         div_quo, div_rem;

  always_comb begin
    accept    = (state == IDLE) && mdu_req_i && !mdu_kill_i;
    sign_a_in = is_signed_a(mdu_op_i) && mdu_port_a_i[XLEN-1];
    sign_b_in = is_signed_b(mdu_op_i) && mdu_port_b_i[XLEN-1];
    abs_a_in  = sign_a_in ? neg_x(mdu_port_a_i) : mdu_port_a_i;
    abs_b_in  = sign_b_in ? neg_x(mdu_port_b_i) : mdu_port_b_i;
    div_special = 1'b0;
    special_res = '0;
    if (!is_mul_op(mdu_op_i) && mdu_port_b_i == '0) begin
      div_special = 1'b1;
      special_res = is_rem_op(mdu_op_i) ? mdu_port_a_i : '1;
    end else if (!is_mul_op(mdu_op_i) && is_signed_b(mdu_op_i) &&
                 mdu_port_a_i == MIN_NEG && mdu_port_b_i == '1) begin
      div_special = 1'b1;
      special_res = is_rem_op(mdu_op_i) ? '0 : mdu_port_a_i;
    end
    div_start = accept && !is_mul_op(mdu_op_i) && !div_special;
  end

  // Shift-add step: the multiplicand slides left as multiplier digits are consumed
  always_comb begin
    mul_digit = {{(2*XLEN-MUL_BITS){1'b0}}, mplier[MUL_BITS-1:0]};
    acc_next  = acc + mcand_sh * mul_digit;
    prod      = (sign_a_q ^ sign_b_q) ? neg_2x(acc_next) : acc_next;
    mul_res   = is_high_op(op_q) ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    mul_last  = (mul_cnt == CNT_W'(MUL_ITERS-1));
    if (is_rem_op(op_q)) div_res = sign_a_q ? neg_x(div_rem) : div_rem;
    else                 div_res = (sign_a_q ^ sign_b_q) ? neg_x(div_quo) : div_quo;
  end

  miriscv_div_radix2 #(.XLEN(XLEN)) u_div (
    .clk_i       (clk_i),
    .arstn_i     (arstn_i),
    .start_i     (div_start),
    .kill_i      (mdu_kill_i),
    .dividend_i  (abs_a_in),
    .divisor_i   (abs_b_in),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state    <= IDLE;
      mul_cnt  <= '0;
      op_q     <= MDU_MUL;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      res_hold <= '0;
    end else if (mdu_kill_i && state != IDLE) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q     <= mdu_op_i;
          sign_a_q <= sign_a_in;
          sign_b_q <= sign_b_in;
          mul_cnt  <= '0;
          if (is_mul_op(mdu_op_i)) state <= MUL;
          else if (div_special)    state <= DONE;
          else                     state <= DIV;
        end
        MUL: begin
          mul_cnt <= mul_cnt + 1'b1;
          if (mul_last) state <= DONE;
        end
        DIV:  if (div_done) state <= DONE;
        DONE: begin
          res_hold <= res_pend;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      acc      <= '0;
      mcand_sh <= {{XLEN{1'b0}}, abs_a_in};
      mplier   <= abs_b_in;
      res_pend <= special_res;
    end else if (state == MUL) begin
      acc      <= acc_next;
      mcand_sh <= mcand_sh << MUL_BITS;
      mplier   <= mplier >> MUL_BITS;
      if (mul_last) res_pend <= mul_res;
    end else if (state == DIV && div_done) begin
      res_pend <= div_res;
    end
  end

  // A kill in DONE must hide the pending result, so valid/result are gated here
  always_comb begin
    mdu_ready_o  = (state == IDLE);
    mdu_busy_o   = (state == MUL) || (state == DIV);
    mdu_valid_o  = (state == DONE) && !mdu_kill_i;
    mdu_result_o = mdu_valid_o ? res_pend : res_hold;
  end

endmodule

// File: tb/tb_miriscv_mdu_iter.sv
// Self-checking bench for miriscv_mdu_iter: directed corner cases plus random
// ops against an arithmetic reference model, on MUL_BITS=32 and MUL_BITS=4.
module tb_miriscv_mdu_iter;
  import miriscv_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        arstn;
  logic        req32, req4, kill;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        rdy32, vld32, busy32, rdy4, vld4, busy4;
  logic [31:0] res32, res4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  miriscv_mdu_iter #(.XLEN(32), .MUL_BITS(32)) dut (
    .clk_i(clk), .arstn_i(arstn), .mdu_req_i(req32), .mdu_op_i(op),
    .mdu_port_a_i(a), .mdu_port_b_i(b), .mdu_kill_i(kill),
    .mdu_ready_o(rdy32), .mdu_valid_o(vld32), .mdu_result_o(res32), .mdu_busy_o(busy32)
  );

  miriscv_mdu_iter #(.XLEN(32), .MUL_BITS(4)) dut4 (
    .clk_i(clk), .arstn_i(arstn), .mdu_req_i(req4), .mdu_op_i(op),
    .mdu_port_a_i(a), .mdu_port_b_i(b), .mdu_kill_i(kill),
    .mdu_ready_o(rdy4), .mdu_valid_o(vld4), .mdu_result_o(res4), .mdu_busy_o(busy4)
  );

  // RV M semantics computed directly with wide arithmetic
  function automatic logic [31:0] ref_mdu(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, uy_s;
    logic [63:0] p;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    uy_s = {32'h0, y};
    p = '0;
    case (o)
      MDU_MUL:    begin p = sx * sy; return p[31:0]; end
      MDU_MULH:   begin p = sx * sy; return p[63:32]; end
      MDU_MULHSU: begin p = sx * uy_s; return p[63:32]; end
      MDU_MULHU:  begin p = {32'h0, x} * {32'h0, y}; return p[63:32]; end
      MDU_DIV: begin
        if (y == 0) return 32'hFFFFFFFF;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return x;
        return $signed(x) / $signed(y);
      end
      MDU_REM: begin
        if (y == 0) return x;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h0;
        return $signed(x) % $signed(y);
      end
      MDU_DIVU: return (y == 0) ? 32'hFFFFFFFF : x / y;
      default:  return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input int mb);
    if (o inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_MULHU}) return 1 + 32 / mb;
    if (y == 0) return 1;
    if ((o == MDU_DIV || o == MDU_REM) && x == 32'h80000000 && y == 32'hFFFFFFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issues one op (called at a negedge), returns result, cycles to valid, busy health
  task automatic run_op(input bit use4, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] r, output int lat, output bit busy_ok);
    int n;
    n = 0;
    while (!(use4 ? rdy4 : rdy32) && n < 200) begin
      @(negedge clk);
      n++;
    end
    op = o; a = x; b = y;
    if (use4) req4 = 1'b1; else req32 = 1'b1;
    @(posedge clk);
    #1;
    req4 = 1'b0; req32 = 1'b0;
    lat = 0; r = '0; busy_ok = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (use4 ? vld4 : vld32) begin
        lat = i;
        r = use4 ? res4 : res32;
        break;
      end
      if (!(use4 ? busy4 : busy32)) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    arstn = 1'b0; req32 = 1'b0; req4 = 1'b0; kill = 1'b0; op = MDU_MUL; a = '0; b = '0;
    repeat (2) @(negedge clk);
    checks++; if (rdy32 !== 1'b1)  begin errors++; $display("FAIL reset_ready got %b exp 1", rdy32); end
    checks++; if (vld32 !== 1'b0)  begin errors++; $display("FAIL reset_valid got %b exp 0", vld32); end
    checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy32); end
    checks++; if (res32 !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp 0", res32); end
    checks++; if (rdy4 !== 1'b1 || res4 !== 32'h0) begin errors++; $display("FAIL reset_dut4 got rdy %b res %h exp 1/0", rdy4, res4); end
    arstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul();
    logic [2:0]  ops [4] = '{MDU_MUL, MDU_MULH, MDU_MULHU, MDU_MULHSU};
    logic [31:0] xa  [4] = '{32'h7, 32'h7, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] xb  [4] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] exp [4] = '{32'hFFFFFFEB, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF};
    logic [31:0] r;
    int lat;
    bit bok;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        run_op(d == 1, ops[i], xa[i], xb[i], r, lat, bok);
        checks++; if (r !== exp[i]) begin errors++; $display("FAIL mul_result dut%0d op%0d got %h exp %h", d, i, r, exp[i]); end
        checks++; if (lat != (d == 1 ? 9 : 2)) begin errors++; $display("FAIL mul_latency dut%0d op%0d got %0d exp %0d", d, i, lat, d == 1 ? 9 : 2); end
      end
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops [3] = '{MDU_DIV, MDU_REM, MDU_REMU};
    logic [31:0] xa  [3] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100};
    logic [31:0] xb  [3] = '{32'd2, 32'd2, 32'd7};
    logic [31:0] exp [3] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd2};
    logic [31:0] r;
    int lat;
    bit bok;
    for (int i = 0; i < 3; i++) begin
      run_op(1'b0, ops[i], xa[i], xb[i], r, lat, bok);
      checks++; if (r !== exp[i]) begin errors++; $display("FAIL div_result op%0d got %h exp %h", i, r, exp[i]); end
      checks++; if (lat != 33) begin errors++; $display("FAIL div_latency op%0d got %0d exp 33", i, lat); end
      checks++; if (!bok) begin errors++; $display("FAIL div_busy op%0d got busy low exp busy high k+1..k+32", i); end
    end
  endtask

  task automatic test_special();
    logic [2:0]  ops [4] = '{MDU_DIVU, MDU_REM, MDU_DIV, MDU_REM};
    logic [31:0] xa  [4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
    logic [31:0] xb  [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] exp [4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0};
    logic [31:0] r;
    int lat;
    bit bok;
    for (int i = 0; i < 4; i++) begin
      run_op(1'b0, ops[i], xa[i], xb[i], r, lat, bok);
      checks++; if (r !== exp[i]) begin errors++; $display("FAIL special_result case%0d got %h exp %h", i, r, exp[i]); end
      checks++; if (lat != 1) begin errors++; $display("FAIL special_latency case%0d got %0d exp 1", i, lat); end
    end
  endtask

  task automatic test_kill();
    logic [31:0] prev, r;
    int lat;
    bit bok, saw;
    prev = res32;
    saw = 1'b0;
    op = MDU_DIV; a = 32'd1000; b = 32'd7; req32 = 1'b1;
    @(posedge clk);
    #1 req32 = 1'b0;
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      if (vld32) saw = 1'b1;
    end
    @(posedge clk);
    #1 kill = 1'b1;
    @(negedge clk);
    if (vld32) saw = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    @(negedge clk);
    if (vld32) saw = 1'b1;
    checks++; if (saw) begin errors++; $display("FAIL kill_no_valid got valid pulse exp none"); end
    checks++; if (rdy32 !== 1'b1) begin errors++; $display("FAIL kill_ready got %b exp 1", rdy32); end
    checks++; if (res32 !== prev) begin errors++; $display("FAIL kill_result_hold got %h exp %h", res32, prev); end
    run_op(1'b0, MDU_MUL, 32'd3, 32'd4, r, lat, bok);
    checks++; if (r !== 32'd12) begin errors++; $display("FAIL kill_then_mul got %h exp %h", r, 32'd12); end
    checks++; if (lat != 2) begin errors++; $display("FAIL kill_then_mul_latency got %0d exp 2", lat); end
  endtask

  task automatic test_reset_mid();
    op = MDU_DIV; a = 32'd100; b = 32'd7; req32 = 1'b1;
    @(posedge clk);
    #1 req32 = 1'b0;
    repeat (4) @(posedge clk);
    #2 arstn = 1'b0;
    #1;
    checks++; if (rdy32 !== 1'b1 || busy32 !== 1'b0 || vld32 !== 1'b0 || res32 !== 32'h0) begin
      errors++; $display("FAIL async_reset got rdy %b busy %b vld %b res %h exp 1 0 0 0", rdy32, busy32, vld32, res32);
    end
    @(negedge clk);
    arstn = 1'b1;
    @(negedge clk);
    op = MDU_MUL; a = 32'd3; b = 32'd4; kill = 1'b1; req32 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (vld32 !== 1'b0 || busy32 !== 1'b0) begin errors++; $display("FAIL req_kill_idle cyc%0d got vld %b busy %b exp 0 0", i, vld32, busy32); end
    end
    req32 = 1'b0; kill = 1'b0;
    @(negedge clk);
    checks++; if (rdy32 !== 1'b1 || res32 !== 32'h0) begin errors++; $display("FAIL req_kill_idle_after got rdy %b res %h exp 1 0", rdy32, res32); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r, x, y;
    logic [2:0]  o;
    int lat;
    bit bok;
    for (int i = 0; i < 6; i++) begin
      o = 3'($urandom_range(0, 7)); x = pick_operand(); y = pick_operand();
      run_op(1'b0, o, x, y, r, lat, bok);
      checks++; if (r !== ref_mdu(o, x, y)) begin errors++; $display("FAIL b2b_result %0d op %0d got %h exp %h", i, o, r, ref_mdu(o, x, y)); end
      @(negedge clk);
      checks++; if (vld32 !== 1'b0 || rdy32 !== 1'b1) begin errors++; $display("FAIL b2b_after_done %0d got vld %b rdy %b exp 0 1", i, vld32, rdy32); end
      checks++; if (res32 !== r) begin errors++; $display("FAIL b2b_result_hold %0d got %h exp %h", i, res32, r); end
    end
  endtask

  task automatic test_random();
    logic [31:0] r, x, y;
    logic [2:0]  o;
    int lat;
    bit bok, use4;
    for (int i = 0; i < 150; i++) begin
      use4 = i[0];
      o = 3'($urandom_range(0, 7)); x = pick_operand(); y = pick_operand();
      run_op(use4, o, x, y, r, lat, bok);
      checks++; if (r !== ref_mdu(o, x, y)) begin errors++; $display("FAIL rand_result %0d dut4=%0d op %0d a %h b %h got %h exp %h", i, use4, o, x, y, r, ref_mdu(o, x, y)); end
      checks++; if (lat != ref_lat(o, x, y, use4 ? 4 : 32)) begin errors++; $display("FAIL rand_latency %0d dut4=%0d op %0d got %0d exp %0d", i, use4, o, lat, ref_lat(o, x, y, use4 ? 4 : 32)); end
      checks++; if (!bok) begin errors++; $display("FAIL rand_busy %0d dut4=%0d got busy low before valid exp high", i, use4); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_kill();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
